rhythm_lanes: RTL and testbench

Parametrised multi-lane rhythm-game engine, the successor to the fixed two-lane game core. It scrolls LANES note patterns toward a hit zone at a programmable step rate and judges synchronised button presses per lane. It keeps hit, miss, streak and score counters and reports a finished track. It sits between the top-level pushbuttons and the seven-segment/LED display logic.

---
 rtl/rhythm_lanes.sv | 183 ++++++++++++++++++
 tb/tb_rhythm_lanes.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rhythm_lanes.sv
// rhythm_lanes: multi-lane scrolling note engine that judges synchronised button presses per lane.
// Optional feature macro RHYTHM_WRONG_PRESS_EN: a press on an empty hit zone counts as a miss.
module rhythm_lanes #(
    parameter int LANES       = 4,
    parameter int PATTERN_LEN = 32,
    parameter int TRACK_LEN   = 8,
    parameter int TICK_W      = 23
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           start,
    input  logic [TICK_W-1:0]              div,
    input  logic [LANES*PATTERN_LEN-1:0]   patterns,
    input  logic [LANES-1:0]               buttons,
    output logic [LANES*TRACK_LEN-1:0]     track,
    output logic [7:0]                     num_hits,
    output logic [7:0]                     num_misses,
    output logic [7:0]                     score,
    output logic                           hit,
    output logic                           missed,
    output logic                           done
);
    localparam int STEPS  = PATTERN_LEN + TRACK_LEN;
    localparam int STEP_W = $clog2(STEPS + 1);
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2, DONE = 2'd3} state_t;

    state_t                         state_r, state_next_s;
    logic [TICK_W-1:0]              div_r, timer_r;
    logic [STEP_W-1:0]              step_cnt_r;
    logic [LANES*PATTERN_LEN-1:0]   src_r, src_next_s;
    logic [LANES*TRACK_LEN-1:0]     track_r, track_next_s;
    logic [LANES-1:0]               meta_r, sync_r, prev_r, rise_s, hit_lane_s, miss_lane_s;
    logic [7:0]                     hits_r, misses_r, score_r, streak_r;
    logic                           hit_r, missed_r, done_r;
    logic                           playing_s, step_s, last_step_s;
    logic [CNT_W-1:0]               n_hit_s, n_miss_s, need_s, bonus_s;
    logic [TRACK_LEN-1:0]           lane_s;
    logic [PATTERN_LEN-1:0]         src_lane_s;

    function automatic logic [CNT_W-1:0] count_ones(input logic [LANES-1:0] v);
        logic [CNT_W-1:0] n;
        n = {CNT_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            n = n + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [CNT_W:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {{(8-CNT_W){1'b0}}, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign rise_s      = sync_r & ~prev_r;
    assign playing_s   = (state_r == PLAY);
    assign step_s      = playing_s && (timer_r == div_r);
    assign last_step_s = step_s && (step_cnt_r == STEP_W'(STEPS - 1));

    // Next-state selection; start restarts the track from any state.
    always_comb begin
        state_next_s = state_r;
        if (start) begin
            state_next_s = LOAD;
        end else begin
            case (state_r)
                IDLE:    state_next_s = IDLE;
                LOAD:    state_next_s = PLAY;
                PLAY:    state_next_s = last_step_s ? DONE : PLAY;
                DONE:    state_next_s = DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Per-lane judging and scrolling; a press is judged on the pre-shift hit-zone bit.
    always_comb begin
        track_next_s = track_r;
        src_next_s   = src_r;
        hit_lane_s   = {LANES{1'b0}};
        miss_lane_s  = {LANES{1'b0}};
        lane_s       = {TRACK_LEN{1'b0}};
        src_lane_s   = {PATTERN_LEN{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            lane_s        = track_r[k*TRACK_LEN +: TRACK_LEN];
            src_lane_s    = src_r[k*PATTERN_LEN +: PATTERN_LEN];
            hit_lane_s[k] = playing_s & rise_s[k] & lane_s[0];
`ifdef RHYTHM_WRONG_PRESS_EN
            miss_lane_s[k] = (step_s & lane_s[0] & ~hit_lane_s[k]) | (playing_s & rise_s[k] & ~lane_s[0]);
`else
            miss_lane_s[k] = step_s & lane_s[0] & ~hit_lane_s[k];
`endif
            if (step_s) begin
                lane_s     = {src_lane_s[0], lane_s[TRACK_LEN-1:1]};
                src_lane_s = {1'b0, src_lane_s[PATTERN_LEN-1:1]};
            end else begin
                lane_s[0]  = lane_s[0] & ~hit_lane_s[k];
            end
            track_next_s[k*TRACK_LEN +: TRACK_LEN]   = lane_s;
            src_next_s[k*PATTERN_LEN +: PATTERN_LEN] = src_lane_s;
        end
    end

    // Hit/miss counts and double-score bonus; the streak grows hit by hit within a cycle.
    always_comb begin
        n_hit_s  = count_ones(hit_lane_s);
        n_miss_s = count_ones(miss_lane_s);
        need_s   = 4'd4 - {2'b00, streak_r[1:0]};
        if (streak_r >= 8'd4) begin
            bonus_s = n_hit_s;
        end else if (n_hit_s > need_s) begin
            bonus_s = n_hit_s - need_s;
        end else begin
            bonus_s = 4'd0;
        end
    end

    // State, synchroniser, track and counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r    <= IDLE;
            meta_r     <= {LANES{1'b0}};
            sync_r     <= {LANES{1'b0}};
            prev_r     <= {LANES{1'b0}};
            div_r      <= {TICK_W{1'b0}};
            timer_r    <= {TICK_W{1'b0}};
            step_cnt_r <= {STEP_W{1'b0}};
            src_r      <= {(LANES*PATTERN_LEN){1'b0}};
            track_r    <= {(LANES*TRACK_LEN){1'b0}};
            hits_r     <= 8'd0;
            misses_r   <= 8'd0;
            score_r    <= 8'd0;
            streak_r   <= 8'd0;
            hit_r      <= 1'b0;
            missed_r   <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            meta_r  <= buttons;
            sync_r  <= meta_r;
            prev_r  <= sync_r;
            state_r <= state_next_s;
            done_r  <= (state_next_s == DONE);
            if (start) begin
                div_r      <= div;
                src_r      <= patterns;
                timer_r    <= {TICK_W{1'b0}};
                step_cnt_r <= {STEP_W{1'b0}};
                track_r    <= {(LANES*TRACK_LEN){1'b0}};
                hits_r     <= 8'd0;
                misses_r   <= 8'd0;
                score_r    <= 8'd0;
                streak_r   <= 8'd0;
                hit_r      <= 1'b0;
                missed_r   <= 1'b0;
            end else if (playing_s) begin
                track_r    <= track_next_s;
                src_r      <= src_next_s;
                timer_r    <= step_s ? {TICK_W{1'b0}} : timer_r + TICK_W'(1);
                step_cnt_r <= step_cnt_r + {{(STEP_W-1){1'b0}}, step_s};
                hits_r     <= sat_add(hits_r, {1'b0, n_hit_s});
                misses_r   <= sat_add(misses_r, {1'b0, n_miss_s});
                score_r    <= sat_add(score_r, {1'b0, n_hit_s} + {1'b0, bonus_s});
                streak_r   <= (n_miss_s != 4'd0) ? 8'd0 : sat_add(streak_r, {1'b0, n_hit_s});
                hit_r      <= (n_hit_s != 4'd0);
                missed_r   <= (n_miss_s != 4'd0);
            end else begin
                hit_r      <= 1'b0;
                missed_r   <= 1'b0;
            end
        end
    end

    assign track      = track_r;
    assign num_hits   = hits_r;
    assign num_misses = misses_r;
    assign score      = score_r;
    assign hit        = hit_r;
    assign missed     = missed_r;
    assign done       = done_r;

endmodule

// File: tb/tb_rhythm_lanes.sv
// Directed bench for rhythm_lanes: a note-position model checked every cycle plus literal end-of-track checks.
module tb_rhythm_lanes;
    localparam int L  = 8;
    localparam int P  = 32;
    localparam int T  = 8;
    localparam int TW = 23;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             start = 1'b0;
    logic [TW-1:0]    div = '0;
    logic [L*P-1:0]   patterns = '0;
    logic [L-1:0]     buttons = '0;
    logic [L*T-1:0]   track;
    logic [7:0]       num_hits, num_misses, score;
    logic             hit, missed, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rhythm_lanes #(.LANES(L), .PATTERN_LEN(P), .TRACK_LEN(T), .TICK_W(TW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .div(div), .patterns(patterns),
        .buttons(buttons), .track(track), .num_hits(num_hits), .num_misses(num_misses),
        .score(score), .hit(hit), .missed(missed), .done(done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a note j of lane k sits at position T+j-s after s steps unless it was hit.
    int          m_state;   // 0 idle, 1 load, 2 play, 3 done
    int          m_div, m_cyc, m_hits, m_misses, m_score, m_streak;
    bit [P-1:0]  m_pat [L];
    bit [P-1:0]  m_taken [L];
    bit [L-1:0]  m_meta, m_sync, m_prev;
    bit          m_hit, m_missed;

    function automatic int steps_done();
        if (m_state == 3) return P + T;
        if (m_state == 2) return m_cyc / (m_div + 1);
        return 0;
    endfunction

    function automatic bit note_at(input int k, input int s, input int p);
        int j;
        j = s + p - T;
        if (j < 0 || j >= P) return 1'b0;
        return m_pat[k][j] & ~m_taken[k][j];
    endfunction

    function automatic logic [L*T-1:0] exp_track();
        logic [L*T-1:0] v;
        int s;
        v = '0;
        s = steps_done();
        for (int k = 0; k < L; k++)
            for (int p = 0; p < T; p++)
                v[k*T + p] = note_at(k, s, p);
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_div = 0; m_cyc = 0;
        m_hits = 0; m_misses = 0; m_score = 0; m_streak = 0;
        m_meta = '0; m_sync = '0; m_prev = '0;
        m_hit = 1'b0; m_missed = 1'b0;
        for (int k = 0; k < L; k++) begin
            m_pat[k] = '0;
            m_taken[k] = '0;
        end
    endtask

    task automatic model_advance();
        bit [L-1:0] rise;
        int s, nh, nm;
        bit is_step, b0;
        rise = m_sync & ~m_prev;
        m_hit = 1'b0;
        m_missed = 1'b0;
        if (start) begin
            m_state = 1; m_div = int'(div); m_cyc = 0;
            m_hits = 0; m_misses = 0; m_score = 0; m_streak = 0;
            for (int k = 0; k < L; k++) begin
                m_pat[k] = patterns[k*P +: P];
                m_taken[k] = '0;
            end
        end else if (m_state == 1) begin
            m_state = 2;
            m_cyc = 0;
        end else if (m_state == 2) begin
            s = m_cyc / (m_div + 1);
            is_step = ((m_cyc % (m_div + 1)) == m_div);
            nh = 0;
            nm = 0;
            for (int k = 0; k < L; k++) begin
                b0 = note_at(k, s, 0);
                if (rise[k] && b0) begin
                    nh++;
                    m_taken[k][s - T] = 1'b1;
                end else if (b0 && is_step) begin
                    nm++;
`ifdef RHYTHM_WRONG_PRESS_EN
                end else if (rise[k]) begin
                    nm++;
`endif
                end
            end
            for (int i = 0; i < nh; i++) begin
                m_score += (m_streak >= 4) ? 2 : 1;
                if (m_score > 255) m_score = 255;
                if (m_streak < 255) m_streak++;
            end
            if (nm > 0) m_streak = 0;
            m_hits += nh;
            if (m_hits > 255) m_hits = 255;
            m_misses += nm;
            if (m_misses > 255) m_misses = 255;
            m_hit = (nh > 0);
            m_missed = (nm > 0);
            m_cyc++;
            if (is_step && (s + 1 == P + T)) m_state = 3;
        end
        m_prev = m_sync;
        m_sync = m_meta;
        m_meta = buttons;
    endtask

    // Compare every cycle on the falling edge, then predict the next rising edge.
    always @(negedge clk) begin
        if (!n_rst) model_reset();
        check("track", 64'(track), 64'(exp_track()));
        check("num_hits", 64'(num_hits), 64'(m_hits));
        check("num_misses", 64'(num_misses), 64'(m_misses));
        check("score", 64'(score), 64'(m_score));
        check("hit", 64'(hit), 64'(m_hit));
        check("missed", 64'(missed), 64'(m_missed));
        check("done", 64'(done), 64'(m_state == 3));
        if (n_rst) model_advance();
    end

    logic [L-1:0] sched [0:511];
    bit           hit_log [0:511];
    bit           miss_log [0:511];

    task automatic clk_step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 512; i++) begin
            sched[i] = '0;
            hit_log[i] = 1'b0;
            miss_log[i] = 1'b0;
        end
    endtask

    // sched[c] drives the buttons so that the press is judged in PLAY cycle c.
    task automatic run_track(input int d, input logic [L*P-1:0] pats, output int edges);
        div = TW'(d);
        patterns = pats;
        start = 1'b1;
        clk_step();
        start = 1'b0;
        edges = 1;
        buttons = sched[1];
        while (!done && edges < 400) begin
            clk_step();
            edges++;
            buttons = sched[edges];
            hit_log[edges] = hit;
            miss_log[edges] = missed;
        end
        buttons = '0;
        check("track_finished", 64'(done), 64'd1);
    endtask

    initial begin
        int edges, nmiss;

        // Reset state
        repeat (3) clk_step();
        check("rst_num_hits", 64'(num_hits), 64'd0);
        check("rst_num_misses", 64'(num_misses), 64'd0);
        check("rst_score", 64'(score), 64'd0);
        check("rst_track", 64'(track), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        n_rst = 1'b1;
        repeat (2) clk_step();

        // Two lanes of all-ones, div=0, no presses
        clear_sched();
        run_track(0, {{((L-2)*P){1'b0}}, {(2*P){1'b1}}}, edges);
        check("a_edges", 64'(edges), 64'd42);
        check("a_misses", 64'(num_misses), 64'd64);
        check("a_score", 64'(score), 64'd0);
        check("a_hits", 64'(num_hits), 64'd0);

        // Alternating notes in lane 0, each pressed one cycle into its hit window
        clear_sched();
        for (int j = 0; j < P; j += 2) sched[(T + j) * 4 + 1] = 8'h01;
        run_track(3, {{((L-1)*P){1'b0}}, 32'h5555_5555}, edges);
        check("b_edges", 64'(edges), 64'd162);
        check("b_hits", 64'(num_hits), 64'd16);
        check("b_misses", 64'(num_misses), 64'd0);
        check("b_score", 64'(score), 64'd28);

        // Press lands in the same cycle as the step that would shift the note out
        clear_sched();
        sched[T * 4 + 3] = 8'h01;
        run_track(3, {{((L-1)*P){1'b0}}, 32'h0000_0001}, edges);
        nmiss = 0;
        for (int i = 0; i < 512; i++) nmiss += int'(miss_log[i]);
        check("c_hits", 64'(num_hits), 64'd1);
        check("c_misses", 64'(num_misses), 64'd0);
        check("c_hit_pulse", 64'(hit_log[38]), 64'd1);
        check("c_no_missed_pulse", 64'(nmiss), 64'd0);

        // Streak of 4, then hit in lane 0 with a miss in lane 1 in the same cycle
        clear_sched();
        for (int j = 0; j < 6; j++) sched[(T + j) * 4 + 3] = 8'h01;
        run_track(3, {{((L-2)*P){1'b0}}, 32'h0000_0010, 32'h0000_003F}, edges);
        check("d_hit_pulse", 64'(hit_log[54]), 64'd1);
        check("d_missed_pulse", 64'(miss_log[54]), 64'd1);
        check("d_hits", 64'(num_hits), 64'd6);
        check("d_misses", 64'(num_misses), 64'd1);
        check("d_score_streak_reset", 64'(score), 64'd7);

        // Press on an empty hit zone
        clear_sched();
        sched[5] = 8'h04;
        run_track(0, {(L*P){1'b0}}, edges);
        check("f_hits", 64'(num_hits), 64'd0);
`ifdef RHYTHM_WRONG_PRESS_EN
        check("f_wrong_press", 64'(num_misses), 64'd1);
`else
        check("f_wrong_press", 64'(num_misses), 64'd0);
`endif

        // 256 misses saturate at 255
        clear_sched();
        run_track(0, {(L*P){1'b1}}, edges);
        check("e_edges", 64'(edges), 64'd42);
        check("e_misses_sat", 64'(num_misses), 64'd255);
        check("e_score", 64'(score), 64'd0);

        // Asynchronous reset in the middle of play
        clear_sched();
        div = '0;
        patterns = {(L*P){1'b1}};
        start = 1'b1;
        clk_step();
        start = 1'b0;
        repeat (29) clk_step();
        check("m_misses_before", 64'(num_misses), 64'd160);
        n_rst = 1'b0;
        #1;
        check("m_misses_async", 64'(num_misses), 64'd0);
        check("m_track_async", 64'(track), 64'd0);
        check("m_done_async", 64'(done), 64'd0);
        repeat (2) clk_step();
        n_rst = 1'b1;
        repeat (3) clk_step();
        check("m_idle_track", 64'(track), 64'd0);
        check("m_idle_misses", 64'(num_misses), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
